// File: rtl/instr_decode_stage.sv
// Decode stage: classifies RV32 instruction words, builds the sign-extended immediate
// and buffers decoded entries in a 2-deep FIFO between valid/ready handshakes.
//
// state   | meaning
// S_EMPTY | no entry buffered; outputs show the idle pattern
// S_ONE   | one entry, held in slot 0
// S_FULL  | two entries; slot 0 is the oldest, in_ready low
module instr_decode_stage #(
    parameter int XLEN      = 32,
    parameter bit EN_SYSTEM = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_type,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_funct3,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
    localparam logic [2:0] T_O = 3'd6;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    // Entry layout: {type, imm, rs1, rs2, rd, funct3, pc}
    localparam int EW = 3 + XLEN + 5 + 5 + 5 + 3 + XLEN;
    localparam logic [EW-1:0] ENT_IDLE = {T_O, {(EW-3){1'b0}}};

    logic [1:0]       r_state;
    logic [EW-1:0]    r_slot0;
    logic [EW-1:0]    r_slot1;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic [6:0]       w_opcode;
    logic [2:0]       w_type;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [EW-1:0]    w_new;
    logic             w_accept;
    logic             w_deliver;

    assign w_opcode = in_instr[6:0];

    always_comb begin
        w_type = T_O;
        case (w_opcode)
            7'b0110011:                         w_type = T_R;
            7'b0010011, 7'b0000011, 7'b1100111: w_type = T_I;
            7'b0100011:                         w_type = T_S;
            7'b1100011:                         w_type = T_B;
            7'b0110111, 7'b0010111:             w_type = T_U;
            7'b1101111:                         w_type = T_J;
            7'b1110011, 7'b0001111:             w_type = EN_SYSTEM ? T_I : T_O;
            default:                            w_type = T_O;
        endcase
    end

    always_comb begin
        w_imm32 = 32'd0;
        case (w_type)
            T_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            T_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            T_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            T_U: w_imm32 = {in_instr[31:12], 12'd0};
            T_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // Signed size cast sign-extends the 32-bit immediate to XLEN.
    assign w_imm = XLEN'($signed(w_imm32));

    assign w_new = {w_type, w_imm, in_instr[19:15], in_instr[24:20], in_instr[11:7],
                    in_instr[14:12], in_pc};

    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = out_valid && out_ready;

    assign {out_type, out_imm, out_rs1, out_rs2, out_rd, out_funct3, out_pc} = r_slot0;
    assign out_illegal = out_valid && (out_type == T_O);
    assign illegal_cnt = r_illegal_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_deliver && out_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
        end
    end

    // Slot 0 always holds the oldest entry and reverts to the idle pattern when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_slot0 <= ENT_IDLE;
            r_slot1 <= ENT_IDLE;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_slot0 <= ENT_IDLE;
            r_slot1 <= ENT_IDLE;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_slot0 <= w_new;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_deliver) begin
                        r_slot0 <= w_new;
                    end else if (w_accept) begin
                        r_slot1 <= w_new;
                        r_state <= S_FULL;
                    end else if (w_deliver) begin
                        r_slot0 <= ENT_IDLE;
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_deliver) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= ENT_IDLE;
                        r_state <= S_ONE;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_slot0 <= ENT_IDLE;
                    r_slot1 <= ENT_IDLE;
                end
            endcase
        end
    end

endmodule
